// File: rtl/if_prefetch_pkg.sv
// Shared widths, constants and the FIFO entry layout for the NJU_MIPS instruction-fetch front end.
package if_prefetch_pkg;

  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam int          IFQ_DEPTH        = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifq_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with a clear input; head word is readable combinationally.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale words are masked by the count.
  always_ff @(posedge clk) begin
    if (w_push && !clear && !rst) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch.sv
// Fetch PC, ROM interface and prefetch queue feeding decode over valid/ready.
// Define IF_BYPASS_EN to forward the ROM word straight to decode when the queue is empty.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0]      rom_data_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  input  logic                   id_ready_i
);

  logic                   r_running;
  logic [INST_ADDR_W-1:0] r_fetch_pc;

  logic       w_full;
  logic       w_empty;
  logic       w_fetch_en;
  logic       w_bypass;
  logic       w_push;
  logic       w_pop;
  logic       w_fifo_valid;
  ifq_entry_t w_din;
  ifq_entry_t w_dout;

  // rst gating keeps the ROM and decode quiet even if running was set before a mid-stream reset.
  assign w_fetch_en = r_running & ~flush_i & ~w_full & ~rst;

`ifdef IF_BYPASS_EN
  assign w_bypass = w_empty & w_fetch_en & id_ready_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = w_fetch_en & ~w_bypass;
  assign w_fifo_valid = ~w_empty & ~flush_i & ~rst;
  assign w_pop        = w_fifo_valid & id_ready_i;
  assign w_din        = '{pc: r_fetch_pc, inst: rom_data_i};

  if_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (flush_i),
    .full  (w_full),
    .empty (w_empty),
    .din   (w_din),
    .dout  (w_dout)
  );

  assign rom_ce_o   = w_fetch_en;
  assign rom_addr_o = r_fetch_pc;

  always_comb begin
    id_valid_o = w_fifo_valid | w_bypass;
    id_pc_o    = w_dout.pc;
    id_inst_o  = w_dout.inst;
    if (rst) begin
      id_pc_o   = ZERO_WORD;
      id_inst_o = ZERO_WORD;
    end else if (w_bypass) begin
      id_pc_o   = r_fetch_pc;
      id_inst_o = rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_running  <= 1'b0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_running <= 1'b1;
      if (flush_i)         r_fetch_pc <= align_pc(flush_pc_i);
      else if (w_fetch_en) r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed plus random stimulus for if_prefetch, checked against a queue-based fetch model.
module tb_if_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  bit          m_running;
  logic [31:0] q_pc[$];

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  always #5 clk = ~clk;

  if_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_o   (rom_ce),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .id_valid_o (id_valid),
    .id_pc_o    (id_pc),
    .id_inst_o  (id_inst),
    .id_ready_i (ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit r, input bit rdy, input bit fl, input logic [31:0] fpc);
    bit          e_ce;
    bit          e_byp;
    bit          e_valid;
    logic [31:0] e_pc;
    @(negedge clk);
    rst = r; ready = rdy; flush = fl; flush_pc = fpc;
    #1;
    e_ce  = !r && m_running && !fl && (q_pc.size() < DEPTH);
    e_byp = 1'b0;
`ifdef IF_BYPASS_EN
    e_byp = e_ce && rdy && (q_pc.size() == 0);
`endif
    e_valid = !r && !fl && ((q_pc.size() > 0) || e_byp);
    e_pc    = e_byp ? m_pc : ((q_pc.size() > 0) ? q_pc[0] : 32'h0);

    chk("rom_ce", {31'd0, rom_ce}, {31'd0, e_ce});
    chk("id_valid", {31'd0, id_valid}, {31'd0, e_valid});
    if (!r) chk("rom_addr", rom_addr, m_pc);
    if (r) begin
      chk("id_pc_rst", id_pc, 32'h0);
      chk("id_inst_rst", id_inst, 32'h0);
    end else if (e_valid) begin
      chk("id_pc", id_pc, e_pc);
      chk("id_inst", id_inst, rom_fn(e_pc));
      if (rdy) $display("deliver pc=%h inst=%h", e_pc, rom_fn(e_pc));
    end

    if (r) begin
      q_pc.delete();
      m_pc      = RST_PC;
      m_running = 1'b0;
    end else begin
      if (fl) begin
        q_pc.delete();
        m_pc = {fpc[31:2], 2'b00};
      end else begin
        if (e_valid && rdy && !e_byp) void'(q_pc.pop_front());
        if (e_ce) begin
          if (!e_byp) q_pc.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      m_running = 1'b1;
    end
  endtask

  initial begin
    m_pc      = RST_PC;
    m_running = 1'b0;

    // Reset, including flush asserted together with reset.
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'h0000_0040);

    // Release and stream with decode always ready.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h0);

    // Back-pressure until full, then drain.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 32'h0);

    // Redirect to an unaligned target.
    step(0, 1, 1, 32'h0000_0103);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0);

    // Redirect near the top of the address space to exercise the wrap.
    step(0, 1, 1, 32'hFFFF_FFF4);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h0);

    // Flush while full.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0000_2000);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0);

    // Reset mid-stream discards queued entries.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
